// File: rtl/lane_id_collector_pkg.sv
// Shared PCS package for the lane ID collector.
// Holds the default lane count, the ID width, the retry timeout
// and the collector FSM state encodings.
package lane_id_collector_pkg;

  localparam int PCS_N_LANES      = 20;
  localparam int PCS_NB_ID        = $clog2(PCS_N_LANES);
  localparam int ERR_RETRY_CYCLES = 16;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    CAPTURE   = 3'd1,
    CHECK     = 3'd2,
    LOCKED    = 3'd3,
    ERROR     = 3'd4
  } lid_state_e;

  // Physical lane 0 lives in the most significant field of an ID bus.
  function automatic int field_msb(input int lane, input int n_lanes, input int nb_id);
    return (n_lanes - lane) * nb_id - 1;
  endfunction

endpackage

// File: rtl/lane_id_capture.sv
// Per-lane match counter and ID latch.
// Counts AM matches while capture is enabled, saturating at N_CAPTURE_WAIT,
// and latches the ID carried by each counted match. A match whose ID differs
// from the latched one restarts the count at 1 with the new ID.
// Ports:
//   i_clock    clock, rising edge
//   i_reset    asynchronous active-high reset
//   i_clear    synchronous counter clear (has priority over capture)
//   i_capture  qualified capture window
//   i_match    AM match pulse for this lane
//   i_id       decoded ID for this lane
//   o_id       latched ID
//   o_done     counter has reached N_CAPTURE_WAIT
module lane_id_capture
  import lane_id_collector_pkg::*;
#(
  parameter int NB_ID          = PCS_NB_ID,
  parameter int N_CAPTURE_WAIT = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_capture,
  input  logic             i_match,
  input  logic [NB_ID-1:0] i_id,
  output logic [NB_ID-1:0] o_id,
  output logic             o_done
);

  localparam int CNT_W = $clog2(N_CAPTURE_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_CAPTURE_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NB_ID-1:0] id_q, id_d;

  always_comb begin
    cnt_d = cnt_q;
    id_d  = id_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_capture && i_match) begin
      if ((cnt_q != '0) && (i_id != id_q)) begin
        // ID changed under us: this match is the first of a new run.
        cnt_d = CNT_W'(1);
        id_d  = i_id;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
        id_d  = i_id;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
      id_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      id_q  <= id_d;
    end
  end

  assign o_id   = id_q;
  assign o_done = (cnt_q == CNT_MAX);

endmodule

// File: rtl/lane_id_collector.sv
// Lane ID collector: waits for AM lock on all lanes, captures a stable
// logical ID per physical lane, then checks the ID set for duplicates and
// out-of-range values before declaring the lane map valid.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   WAIT_LOCK | waiting for every lane to report AM lock
//   CAPTURE   | counting matches per lane until each ID is trusted
//   CHECK     | walking lanes 0..N_LANES-1, building a one-hot seen vector
//   LOCKED    | ID bus complete and clean, o_ids_valid high
//   ERROR     | duplicate/out-of-range ID, retry after a fixed timeout
//
// Ports:
//   i_clock, i_reset            clock and async active-high reset
//   i_enable, i_valid           both high qualifies a cycle; otherwise hold
//   i_am_lock, i_am_match       per-lane lock / match, MSB is lane 0
//   i_am_id                     per-lane decoded ID, lane 0 in MSB field
//   o_logical_rx_ID             latched IDs, lane 0 in MSB field
//   o_ids_valid, o_id_error     LOCKED / ERROR state indications
//   o_reset_order               one-cycle re-arm pulse for the reorder stage
module lane_id_collector
  import lane_id_collector_pkg::*;
#(
  parameter int N_LANES        = PCS_N_LANES,
  parameter int NB_ID          = $clog2(N_LANES),
  parameter int NB_ID_BUS      = N_LANES * NB_ID,
  parameter int N_CAPTURE_WAIT = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_valid,
  input  logic [N_LANES-1:0]   i_am_lock,
  input  logic [N_LANES-1:0]   i_am_match,
  input  logic [NB_ID_BUS-1:0] i_am_id,
  output logic [NB_ID_BUS-1:0] o_logical_rx_ID,
  output logic                 o_ids_valid,
  output logic                 o_id_error,
  output logic                 o_reset_order
);

  localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int TMR_W = $clog2(ERR_RETRY_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LANES - 1);

  lid_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_LANES-1:0]   seen_q, seen_d;
  logic                 err_q, err_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 reset_order_q, reset_order_d;

  logic                 qual;
  logic                 lock_all;
  logic                 lock_lost;
  logic                 all_done;
  logic                 cnt_clr;
  logic                 cap_en;
  logic [N_LANES-1:0]   lane_done;
  logic [NB_ID-1:0]     lane_id [N_LANES];
  logic [NB_ID-1:0]     cur_id;
  logic                 id_oor;
  logic                 id_dup;
  logic                 lane_bad;

  assign qual      = i_enable & i_valid;
  assign lock_all  = &i_am_lock;
  assign lock_lost = ~lock_all;
  assign all_done  = &lane_done;

  // Counters start from zero on every capture attempt: they are wiped while
  // idle in WAIT_LOCK and whenever lock is lost elsewhere.
  assign cnt_clr = qual && ((state_q == WAIT_LOCK) || lock_lost);
  assign cap_en  = qual && (state_q == CAPTURE) && lock_all;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    lane_id_capture #(
      .NB_ID          (NB_ID),
      .N_CAPTURE_WAIT (N_CAPTURE_WAIT)
    ) u_capture (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_clear   (cnt_clr),
      .i_capture (cap_en),
      .i_match   (i_am_match[N_LANES-1-g]),
      .i_id      (i_am_id[field_msb(g, N_LANES, NB_ID) -: NB_ID]),
      .o_id      (lane_id[g]),
      .o_done    (lane_done[g])
    );

    assign o_logical_rx_ID[field_msb(g, N_LANES, NB_ID) -: NB_ID] = lane_id[g];
  end

  assign cur_id   = lane_id[idx_q];
  assign id_oor   = (int'(cur_id) >= N_LANES);
  assign id_dup   = !id_oor && seen_q[cur_id];
  assign lane_bad = id_oor || id_dup;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    seen_d        = seen_q;
    err_d         = err_q;
    tmr_d         = tmr_q;
    reset_order_d = 1'b0;

    if (qual) begin
      if ((state_q != WAIT_LOCK) && lock_lost) begin
        state_d       = WAIT_LOCK;
        idx_d         = '0;
        seen_d        = '0;
        err_d         = 1'b0;
        reset_order_d = 1'b1;
      end else begin
        case (state_q)
          WAIT_LOCK: begin
            if (lock_all) begin
              state_d       = CAPTURE;
              reset_order_d = 1'b1;
            end
          end
          CAPTURE: begin
            if (all_done) begin
              state_d = CHECK;
              idx_d   = '0;
              seen_d  = '0;
              err_d   = 1'b0;
            end
          end
          CHECK: begin
            if (lane_bad) begin
              err_d = 1'b1;
            end else begin
              seen_d[cur_id] = 1'b1;
            end
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              tmr_d   = TMR_W'(ERR_RETRY_CYCLES - 1);
              state_d = (err_q || lane_bad) ? ERROR : LOCKED;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
          LOCKED: begin
          end
          ERROR: begin
            if (tmr_q == '0) begin
              state_d       = WAIT_LOCK;
              reset_order_d = 1'b1;
            end else begin
              tmr_d = tmr_q - TMR_W'(1);
            end
          end
          default: begin
            state_d = WAIT_LOCK;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= WAIT_LOCK;
      idx_q         <= '0;
      seen_q        <= '0;
      err_q         <= 1'b0;
      tmr_q         <= '0;
      reset_order_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      seen_q        <= seen_d;
      err_q         <= err_d;
      tmr_q         <= tmr_d;
      reset_order_q <= reset_order_d;
    end
  end

  assign o_ids_valid   = (state_q == LOCKED);
  assign o_id_error    = (state_q == ERROR);
  assign o_reset_order = reset_order_q;

endmodule

// File: tb/tb_lane_id_collector.sv
module tb_lane_id_collector;

  localparam int N  = 20;
  localparam int NB = 5;
  localparam int BW = N * NB;

  logic          clk;
  logic          rst;
  logic          en;
  logic          vld;
  logic [N-1:0]  lock;
  logic [N-1:0]  match;
  logic [BW-1:0] am_id;
  logic [BW-1:0] rx_id;
  logic          ids_valid;
  logic          id_error;
  logic          reset_order;

  int n_vec;
  int n_err;
  int ids[N];
  int tmp[N];

  lane_id_collector #(
    .N_LANES        (N),
    .NB_ID          (NB),
    .NB_ID_BUS      (BW),
    .N_CAPTURE_WAIT (4)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_valid         (vld),
    .i_am_lock       (lock),
    .i_am_match      (match),
    .i_am_id         (am_id),
    .o_logical_rx_ID (rx_id),
    .o_ids_valid     (ids_valid),
    .o_id_error      (id_error),
    .o_reset_order   (reset_order)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Lane 0 is shifted in first, so it ends up in the top field.
  function automatic logic [BW-1:0] mk_bus(input int v[N]);
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < N; k++) begin
      b = {b[BW-NB-1:0], NB'(v[k])};
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_matches(input int n);
    repeat (n) begin
      match = '1;
      tick();
    end
    match = '0;
  endtask

  task automatic base_ids();
    for (int k = 0; k < N; k++) ids[k] = 19 - k;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    en    = 1'b1;
    vld   = 1'b1;
    lock  = '0;
    match = '0;
    am_id = '0;

    #23;
    check("rst_ids_valid", ids_valid, 1'b0);
    check("rst_id_error", id_error, 1'b0);
    check("rst_reset_order", reset_order, 1'b0);
    check("rst_rx_id", rx_id, '0);
    rst = 1'b0;
    tick();
    check("idle_no_ro", reset_order, 1'b0);

    // Clean capture, lane k carries 19-k.
    base_ids();
    am_id = mk_bus(ids);
    lock  = '1;
    tick();
    check("t1_ro_on_capture", reset_order, 1'b1);
    send_matches(4);
    check("t1_ro_one_cycle", reset_order, 1'b0);
    tick();
    repeat (19) tick();
    check("t1_not_yet_valid", ids_valid, 1'b0);
    tick();
    check("t1_ids_valid", ids_valid, 1'b1);
    check("t1_no_error", id_error, 1'b0);
    check("t1_rx_id", rx_id, mk_bus(ids));

    // Lock loss while enable is low must wait for a qualified cycle.
    en       = 1'b0;
    lock[10] = 1'b0;
    tick();
    check("en_low_holds_valid", ids_valid, 1'b1);
    check("en_low_no_ro", reset_order, 1'b0);
    en = 1'b1;
    tick();
    check("lockloss_valid_drop", ids_valid, 1'b0);
    check("lockloss_ro", reset_order, 1'b1);
    tick();
    check("lockloss_ro_one_cycle", reset_order, 1'b0);
    lock = '0;
    tick();

    // Lanes 3 and 7 both claim ID 5.
    base_ids();
    ids[3] = 5;
    ids[7] = 5;
    am_id  = mk_bus(ids);
    lock   = '1;
    tick();
    send_matches(4);
    tick();
    repeat (20) tick();
    check("dup_error", id_error, 1'b1);
    check("dup_not_valid", ids_valid, 1'b0);
    repeat (15) tick();
    check("dup_error_held", id_error, 1'b1);
    tick();
    check("dup_retry_error_clr", id_error, 1'b0);
    check("dup_retry_ro", reset_order, 1'b1);
    tick();
    check("dup_recapture_ro", reset_order, 1'b1);
    lock = '0;
    tick();
    tick();

    // Lane 2 carries out-of-range ID 25; then lock loss out of ERROR.
    base_ids();
    ids[2] = 25;
    am_id  = mk_bus(ids);
    lock   = '1;
    tick();
    send_matches(4);
    tick();
    repeat (20) tick();
    check("oor_error", id_error, 1'b1);
    check("oor_not_valid", ids_valid, 1'b0);
    lock = '0;
    tick();
    check("oor_lockloss_error_clr", id_error, 1'b0);
    check("oor_lockloss_ro", reset_order, 1'b1);
    tick();

    // Lane 4 sends 6, 6, then 9 x4; lane 10 takes 15 to keep the set clean.
    base_ids();
    ids[4]  = 9;
    ids[10] = 15;
    tmp     = ids;
    tmp[4]  = 6;
    am_id   = mk_bus(tmp);
    lock    = '1;
    tick();
    send_matches(2);
    am_id = mk_bus(ids);
    send_matches(4);
    tick();
    repeat (19) tick();
    check("restart_delays_check", ids_valid, 1'b0);
    tick();
    check("restart_valid", ids_valid, 1'b1);
    check("restart_rx_id", rx_id, mk_bus(ids));
    lock[10] = 1'b0;
    tick();
    check("locked_drop_valid", ids_valid, 1'b0);
    check("locked_drop_ro", reset_order, 1'b1);
    tick();
    check("locked_drop_ro_one", reset_order, 1'b0);
    lock = '0;
    tick();

    // i_valid low for 5 cycles in the middle of CHECK.
    base_ids();
    am_id = mk_bus(ids);
    lock  = '1;
    tick();
    send_matches(4);
    tick();
    repeat (5) tick();
    vld = 1'b0;
    repeat (5) tick();
    check("vld_low_frozen", ids_valid, 1'b0);
    vld = 1'b1;
    repeat (14) tick();
    check("vld_check_not_done", ids_valid, 1'b0);
    tick();
    check("vld_check_done", ids_valid, 1'b1);
    check("vld_rx_id", rx_id, mk_bus(ids));
    check("vld_no_error", id_error, 1'b0);
    lock = '0;
    tick();

    // Lock loss on the final CHECK cycle beats the move to LOCKED.
    lock = '1;
    tick();
    send_matches(4);
    tick();
    repeat (19) tick();
    lock[0] = 1'b0;
    tick();
    check("prio_lockloss_not_valid", ids_valid, 1'b0);
    check("prio_lockloss_ro", reset_order, 1'b1);
    lock = '0;
    tick();

    // Reset in the middle of CHECK.
    lock = '1;
    tick();
    send_matches(4);
    tick();
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_rx_id", rx_id, '0);
    check("midrst_ro", reset_order, 1'b0);
    lock = '0;
    #2 rst = 1'b0;
    tick();
    check("rst_exit_no_ro", reset_order, 1'b0);
    check("rst_exit_not_valid", ids_valid, 1'b0);
    lock = '1;
    tick();
    send_matches(4);
    tick();
    repeat (20) tick();
    check("post_rst_valid", ids_valid, 1'b1);
    check("post_rst_rx_id", rx_id, mk_bus(ids));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
